// File: rtl/y86_pkg.sv
// Shared Y86-64 SEQ constants: Stat codes, icodes, sequencer state encoding,
// and a helper that identifies instructions that use the data memory.
package y86_pkg;

  localparam int unsigned STAT_W  = 3;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] S_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd3;
  localparam logic [STATE_W-1:0] S_MEMORY    = 3'd4;
  localparam logic [STATE_W-1:0] S_WRITEBACK = 3'd5;
  localparam logic [STATE_W-1:0] S_PCUPD     = 3'd6;
  localparam logic [STATE_W-1:0] S_STOP      = 3'd7;

  typedef struct packed {
    logic adr;
    logic ins;
    logic hlt;
  } fetch_flags_t;

  function automatic logic is_mem_icode(input logic [ICODE_W-1:0] icode);
    case (icode)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: is_mem_icode = 1'b1;
      default:                                     is_mem_icode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_mem_wait_timer.sv
// Counts MEMORY-state wait cycles; timeout_c flags that the wait budget is spent.
module seq_mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Saturates at MAX_WAIT so the counter never wraps back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !timeout_c) begin
      count <= count + CW'(1);
    end
  end

  assign timeout_c = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ sequencer: owns the PC, steps each instruction through the six
// stages with one-hot enables, and tracks the processor Stat code.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned     PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 15,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic [3:0]         icode,
  input  logic               ins,
  input  logic               adr,
  input  logic               hlt,
  input  logic [PC_W-1:0]    new_pc,
  input  logic               dmem_ready,
  input  logic               dmem_err,
  output logic [PC_W-1:0]    PC,
  output logic               f_en,
  output logic               d_en,
  output logic               e_en,
  output logic               m_en,
  output logic               w_en,
  output logic               dmem_req,
  output logic [2:0]         stat,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic [STAT_W-1:0]  stat_d;
  logic [ICODE_W-1:0] icode_q;
  logic               mem_op;
  logic               timeout_c;
  fetch_flags_t       flags;

  assign flags  = '{adr: adr, ins: ins, hlt: hlt};
  assign mem_op = is_mem_icode(icode_q);

  seq_mem_wait_timer #(
    .MAX_WAIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state != S_MEMORY),
    .en        (mem_op && !dmem_ready),
    .timeout_c (timeout_c)
  );

  // Next-state and Stat update
  always_comb begin
    state_d = state;
    stat_d  = stat;
    case (state)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (flags.adr) begin
          stat_d  = STAT_ADR;
          state_d = S_STOP;
        end else if (flags.ins) begin
          stat_d  = STAT_INS;
          state_d = S_STOP;
        end else if (flags.hlt) begin
          stat_d  = STAT_HLT;
          state_d = S_STOP;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY: begin
        // A ready on the timeout cycle still counts as a completed access
        if (!mem_op) begin
          state_d = S_WRITEBACK;
        end else if (dmem_ready) begin
          if (dmem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_STOP;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_c) begin
          stat_d  = STAT_ADR;
          state_d = S_STOP;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = pause ? S_IDLE : S_FETCH;
      S_STOP:      state_d = S_STOP;
      default:     state_d = S_IDLE;
    endcase
  end

  // State, architectural registers, and enables registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      stat     <= STAT_AOK;
      icode_q  <= '0;
      PC       <= RESET_PC;
      retired  <= '0;
      f_en     <= 1'b0;
      d_en     <= 1'b0;
      e_en     <= 1'b0;
      m_en     <= 1'b0;
      w_en     <= 1'b0;
      dmem_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_d;
      stat     <= stat_d;
      if (state == S_FETCH) icode_q <= icode;
      if (state == S_PCUPD) begin
        PC      <= new_pc;
        retired <= retired + CNT_W'(1);
      end
      f_en     <= (state_d == S_FETCH);
      d_en     <= (state_d == S_DECODE);
      e_en     <= (state_d == S_EXECUTE);
      m_en     <= (state_d == S_MEMORY);
      w_en     <= (state_d == S_WRITEBACK);
      dmem_req <= (state_d == S_MEMORY) && mem_op;
      halted   <= (state_d == S_STOP);
    end
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: stage sequencing, memory waits and
// timeout, fault priority, async reset abort, pause, and counter wrap.
module tb_seq_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic [3:0]  icode;
  logic        ins;
  logic        adr;
  logic        hlt;
  logic [63:0] new_pc;
  logic        dmem_ready;
  logic        dmem_err;
  logic [63:0] pc;
  logic        f_en, d_en, e_en, m_en, w_en;
  logic        dmem_req;
  logic [2:0]  stat;
  logic        halted;
  logic [3:0]  retired;

  int errors = 0;
  int checks = 0;

  seq_stage_ctrl #(
    .PC_W        (64),
    .RESET_PC    (64'h0),
    .MEM_TIMEOUT (15),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .icode      (icode),
    .ins        (ins),
    .adr        (adr),
    .hlt        (hlt),
    .new_pc     (new_pc),
    .dmem_ready (dmem_ready),
    .dmem_err   (dmem_err),
    .PC         (pc),
    .f_en       (f_en),
    .d_en       (d_en),
    .e_en       (e_en),
    .m_en       (m_en),
    .w_en       (w_en),
    .dmem_req   (dmem_req),
    .stat       (stat),
    .halted     (halted),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_en(input string tag, input logic [4:0] exp);
    chk(tag, 64'({f_en, d_en, e_en, m_en, w_en}), 64'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // From FETCH: runs a non-memory instruction through PCUPD
  task automatic run_instr(input logic [3:0] ic, input logic [63:0] npc, input logic p);
    icode  = ic;
    new_pc = npc;
    repeat (5) step();
    pause = p;
    step();
    pause = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; icode = 4'h0;
    ins = 1'b0; adr = 1'b0; hlt = 1'b0; new_pc = 64'h0;
    dmem_ready = 1'b0; dmem_err = 1'b0;
    repeat (2) step();
    chk_en("rst_en", 5'b00000);
    chk("rst_req", 64'(dmem_req), 64'(0));
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", 64'(stat), 64'(1));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_retired", 64'(retired), 64'(0));
    rst_n = 1'b1;
    step();
    chk_en("idle_hold", 5'b00000);

    // Test 1: OPq walks through the stages one cycle each
    start = 1'b1; step(); start = 1'b0;
    chk_en("t1_fetch", 5'b10000);
    icode = 4'h6; new_pc = 64'h2;
    step(); chk_en("t1_decode", 5'b01000);
    step(); chk_en("t1_execute", 5'b00100);
    step(); chk_en("t1_memory", 5'b00010);
    chk("t1_noreq", 64'(dmem_req), 64'(0));
    step(); chk_en("t1_wb", 5'b00001);
    step(); chk_en("t1_pcupd", 5'b00000);
    chk("t1_pc_hold", pc, 64'h0);
    step(); chk_en("t1_fetch2", 5'b10000);
    chk("t1_pc", pc, 64'h2);
    chk("t1_retired", 64'(retired), 64'(1));
    chk("t1_stat", 64'(stat), 64'(1));

    // Test 2: mrmovq, ready arrives on the fourth MEMORY cycle
    icode = 4'h5; new_pc = 64'hC;
    repeat (3) step();
    chk_en("t2_mem0", 5'b00010);
    chk("t2_req0", 64'(dmem_req), 64'(1));
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_en("t2_memwait", 5'b00010);
      chk("t2_reqwait", 64'(dmem_req), 64'(1));
    end
    dmem_ready = 1'b1;
    step(); dmem_ready = 1'b0;
    chk_en("t2_wb", 5'b00001);
    chk("t2_req_off", 64'(dmem_req), 64'(0));
    repeat (2) step();
    chk_en("t2_fetch", 5'b10000);
    chk("t2_pc", pc, 64'hC);
    chk("t2_retired", 64'(retired), 64'(2));

    // Ready on the timeout cycle is a success
    icode = 4'hA; new_pc = 64'h20;
    repeat (3) step();
    for (int i = 1; i <= 15; i++) step();
    chk_en("tb_mem15", 5'b00010);
    dmem_ready = 1'b1;
    step(); dmem_ready = 1'b0;
    chk_en("tb_wb", 5'b00001);
    chk("tb_stat", 64'(stat), 64'(1));
    repeat (2) step();
    chk("tb_pc", pc, 64'h20);
    chk("tb_retired", 64'(retired), 64'(3));

    // Test 3: rmmovq never gets ready -> ADR after 15 wait cycles
    icode = 4'h4; new_pc = 64'h2A;
    repeat (3) step();
    for (int i = 1; i <= 15; i++) step();
    chk_en("t3_mem15", 5'b00010);
    step();
    chk_en("t3_stop_en", 5'b00000);
    chk("t3_req", 64'(dmem_req), 64'(0));
    chk("t3_stat", 64'(stat), 64'(3));
    chk("t3_halted", 64'(halted), 64'(1));
    chk("t3_pc", pc, 64'h20);
    chk("t3_retired", 64'(retired), 64'(3));

    // Test 4: all fetch faults at once -> ADR wins; STOP ignores start/pause
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    adr = 1'b1; ins = 1'b1; hlt = 1'b1;
    step();
    adr = 1'b0; ins = 1'b0; hlt = 1'b0;
    chk("t4_stat", 64'(stat), 64'(3));
    chk("t4_halted", 64'(halted), 64'(1));
    chk("t4_pc", pc, 64'h0);
    start = 1'b1; pause = 1'b1;
    repeat (3) step();
    start = 1'b0; pause = 1'b0;
    chk_en("t4_stop_en", 5'b00000);
    chk("t4_stop_halted", 64'(halted), 64'(1));

    // Invalid instruction alone -> INS
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    ins = 1'b1; step(); ins = 1'b0;
    chk("t4_ins", 64'(stat), 64'(4));

    // Test 5: hlt at PC 0x40
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    run_instr(4'h1, 64'h40, 1'b0);
    chk("t5_pc40", pc, 64'h40);
    hlt = 1'b1; step(); hlt = 1'b0;
    chk("t5_stat", 64'(stat), 64'(2));
    chk("t5_pc", pc, 64'h40);
    chk("t5_retired", 64'(retired), 64'(1));

    // Async reset mid-DECODE aborts the instruction
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    run_instr(4'h1, 64'h40, 1'b0);
    icode = 4'h6; new_pc = 64'h42;
    step();
    chk_en("t5_decode", 5'b01000);
    #2 rst_n = 1'b0;
    #1;
    chk_en("t5_abort_en", 5'b00000);
    chk("t5_abort_pc", pc, 64'h0);
    chk("t5_abort_stat", 64'(stat), 64'(1));
    chk("t5_abort_ret", 64'(retired), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    chk_en("t5_idle", 5'b00000);

    // Test 6: pause returns to IDLE, then restart at the new PC
    start = 1'b1; step(); start = 1'b0;
    run_instr(4'h1, 64'h10, 1'b1);
    chk_en("t6_idle", 5'b00000);
    chk("t6_pc", pc, 64'h10);
    chk("t6_retired", 64'(retired), 64'(1));
    repeat (2) step();
    chk_en("t6_idle_hold", 5'b00000);
    start = 1'b1; step(); start = 1'b0;
    chk_en("t6_fetch", 5'b10000);
    chk("t6_fetch_pc", pc, 64'h10);
    for (int i = 1; i <= 15; i++) run_instr(4'h1, 64'h10 + 64'(2 * i), 1'b0);
    chk("t6_wrap", 64'(retired), 64'(0));
    chk("t6_wrap_pc", pc, 64'h2E);
    chk_en("t6_wrap_fetch", 5'b10000);

    // Data memory error -> ADR, no retire
    icode = 4'h9; new_pc = 64'h99;
    repeat (3) step();
    dmem_ready = 1'b1; dmem_err = 1'b1;
    step();
    dmem_ready = 1'b0; dmem_err = 1'b0;
    chk("t7_stat", 64'(stat), 64'(3));
    chk("t7_halted", 64'(halted), 64'(1));
    chk("t7_pc", pc, 64'h2E);
    chk("t7_retired", 64'(retired), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 SEQ core. It owns the architectural PC, steps each instruction through Fetch, Decode, Execute, Memory, Writeback and PC-update, and drives one-hot stage enables to the stage modules. It samples the fetch status flags (ins, adr, hlt) and data-memory handshake and keeps the processor Stat code. It sits at the top of the SEQ datapath, feeding PC to fetch and receiving the next PC from pc-update logic.

Parameters:
PC_W, 64, width of PC and next-PC buses
RESET_PC, 64'h0, PC value loaded on reset
MEM_TIMEOUT, 15, maximum MEMORY-state wait cycles before an ADR fault is forced
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin execution
pause  in  1  return to IDLE after the current instruction retires
icode  in  4  from fetch, valid during FETCH
ins  in  1  fetch: invalid instruction
adr  in  1  fetch: invalid instruction address
hlt  in  1  fetch: halt instruction
new_pc  in  PC_W  next PC from pc-update logic
dmem_ready  in  1  data memory access complete
dmem_err  in  1  data memory address error, qualified by dmem_ready
PC  out  PC_W  architectural PC to fetch
f_en, d_en, e_en, m_en, w_en  out  1 each  one-hot stage enables
dmem_req  out  1  data memory request
stat  out  3  Y86 Stat: 1 AOK, 2 HLT, 3 ADR, 4 INS
halted  out  1  core stopped (stat != AOK)
retired  out  CNT_W  count of instructions completing PC-update

Behaviour:
- Reset (rst_n=0, async): state=IDLE, PC=RESET_PC, stat=1, retired=0, halted=0, all enables and dmem_req 0. A reset mid-instruction aborts it with no PC update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP. The enable for a state is high for exactly the cycles spent in that state. All outputs are registered or decoded from the state register only.
- IDLE: start=1 -> FETCH next cycle. Otherwise hold.
- FETCH: f_en=1; icode is latched into icode_q at the end of the cycle. Fault priority: adr > ins > hlt.
  - adr -> stat=3.
  - ins -> stat=4.
  - hlt -> stat=2.
  - Any fault -> STOP, PC unchanged (points at the offending instruction), retired unchanged.
  - No fault -> DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY, icode_q in {4,5,8,9,A,B}: m_en=1 and dmem_req=1, held until dmem_ready=1.
  - dmem_ready with dmem_err=1 -> stat=3, STOP.
  - dmem_ready with dmem_err=0 -> WRITEBACK.
  - Wait counter clears on MEMORY entry. If dmem_ready is still 0 after MEM_TIMEOUT wait cycles -> stat=3, STOP.
  - dmem_ready asserted on the same cycle as the timeout is taken as success.
- MEMORY, other icodes: m_en=1 for one cycle, dmem_req=0, dmem_ready ignored -> WRITEBACK.
- WRITEBACK -> PCUPD, one cycle.
- PCUPD: PC<=new_pc; retired<=retired+1, wrapping modulo 2^CNT_W. pause=1 -> IDLE; otherwise FETCH.
- Latency: non-memory instruction = 6 cycles FETCH-to-FETCH. Memory instruction = 6 + wait cycles.
- STOP: halted=1, all enables 0; start and pause ignored; exit only by reset.
- start is ignored outside IDLE. pause is sampled only in PCUPD.

Decomposition:
- y86_pkg:
  - Stat constants STAT_AOK/HLT/ADR/INS.
  - icode constants (IHALT=0 ... IPOPQ=B).
  - State enum.
  - Function is_mem_icode().
- Sub-module seq_mem_wait_timer: counter with clear, enable and timeout output, sized by clog2(MEM_TIMEOUT+1).

Test Plan:
1. Reset then start, icode=6 (OPq), new_pc=PC+2, no faults -> f_en..w_en pulse in order, one cycle each; PC goes 0->2 at cycle 6; retired=1; stat=1.
2. icode=5 (mrmovq), dmem_ready raised 3 cycles after MEMORY entry -> m_en and dmem_req high for 4 cycles, then WRITEBACK; 9-cycle instruction.
3. icode=4 (rmmovq), dmem_ready never asserted -> after 15 wait cycles stat=3, halted=1, PC unchanged, retired unchanged.
4. Fetch with adr=1, ins=1, hlt=1 simultaneously -> stat=3 (adr wins), STOP; then start pulses -> no enables asserted.
5. hlt=1 at PC=0x40 -> stat=2, PC stays 0x40; rst_n pulled low mid-DECODE of a later run -> immediate IDLE, PC=RESET_PC, stat=1, retired=0.
6. pause=1 during PCUPD -> IDLE after retire; start -> FETCH at new PC. CNT_W=4 with 16 instructions -> retired wraps to 0.
